// File: rtl/bus_handshake_tx.sv
// Source-side toggle req/ack sender behind a DEPTH-word FIFO. A push into an idle block loads data_out one edge later and toggles req on the edge after that.
// Backpressure: registered in_ready drops when DEPTH words are queued; BUS_HANDSHAKE_TX_STATS_EN adds the sent_count and drop_count counters.
module bus_handshake_tx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clkSrc,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req,
  input  logic             ack,
  output logic             busy
`ifdef BUS_HANDSHAKE_TX_STATS_EN
  ,
  output logic [15:0]      sent_count,
  output logic [15:0]      drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_next;
  logic             ack_s1, ack_s2;
  logic             push, pop;
  logic             req_next;
  logic [WIDTH-1:0] data_next;

  assign push = in_valid & in_ready;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    req_next   = req;
    data_next  = data_out;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          data_next  = mem[rd_ptr];
          state_next = SETUP;
        end
      end
      // data_out has been stable for a full cycle before req flips here
      SETUP: begin
        req_next   = ~req;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s2 == req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clkSrc or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      req      <= 1'b0;
      data_out <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      req      <= req_next;
      data_out <= data_next;
      ack_s1   <= ack;
      ack_s2   <= ack_s1;
      // Both flags come from next-state values, so a pop never glitches them
      in_ready <= (count_next < DEPTH_C);
      busy     <= (state_next != IDLE) || (count_next != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clkSrc) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef BUS_HANDSHAKE_TX_STATS_EN
  always_ff @(posedge clkSrc or negedge rstn) begin
    if (!rstn) begin
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      if (state == WAIT_ACK && state_next == IDLE && sent_count != 16'hFFFF)
        sent_count <= sent_count + 1'b1;
      if (in_valid && !in_ready && drop_count != 16'hFFFF)
        drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_handshake_tx.sv
// Directed bench for bus_handshake_tx: scoreboard of pushed words checked at each req toggle, plus a toggle-ack destination model.
module tb_bus_handshake_tx;

  logic        clkSrc;
  logic        rstn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic        req;
  logic        ack;
  logic        busy;
`ifdef BUS_HANDSHAKE_TX_STATS_EN
  logic [15:0] sent_count;
  logic [15:0] drop_count;
`endif

  bus_handshake_tx #(.WIDTH(32), .DEPTH(4)) dut (
    .clkSrc   (clkSrc),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .req      (req),
    .ack      (ack),
    .busy     (busy)
`ifdef BUS_HANDSHAKE_TX_STATS_EN
    ,
    .sent_count (sent_count),
    .drop_count (drop_count)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  logic [31:0] exp_q[$];
  logic        auto_ack;
  logic        rand_ack;
  logic        manual_ack;

  initial begin
    clkSrc = 1'b0;
    forever #5 clkSrc = ~clkSrc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clkSrc);
    in_valid = 1'b1;
    in_data  = d;
    if (in_ready) exp_q.push_back(d);
    @(posedge clkSrc);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clkSrc);
    while (!in_ready && n < 100) begin
      @(negedge clkSrc);
      n++;
    end
    chk("push_wait_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    if (in_ready) exp_q.push_back(d);
    @(posedge clkSrc);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clkSrc);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clkSrc);
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // Destination: returns ack = req after 0..7 cycles, or follows manual_ack
  initial begin
    int dly;
    ack = 1'b0;
    forever begin
      @(negedge clkSrc or negedge rstn);
      if (!rstn) ack = 1'b0;
      else if (!auto_ack) ack = manual_ack;
      else if (req !== ack) begin
        dly = rand_ack ? int'($urandom_range(7, 0)) : 0;
        for (int i = 0; i < dly; i++) @(negedge clkSrc);
        ack = rstn ? req : 1'b0;
      end
    end
  end

  // Monitor: each req toggle must present the next scoreboard word; hold it until ack matches
  initial begin
    logic        prev_req;
    logic        in_flight;
    logic [31:0] held_dat;
    logic [31:0] exp_w;
    prev_req  = 1'b0;
    in_flight = 1'b0;
    held_dat  = '0;
    forever begin
      @(negedge clkSrc or negedge rstn);
      if (!rstn) begin
        prev_req  = 1'b0;
        in_flight = 1'b0;
      end else if (req !== prev_req) begin
        prev_req = req;
        delivered++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_req observed=%h expected=none", data_out);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("data_at_req", data_out, exp_w);
        end
        held_dat  = data_out;
        in_flight = 1'b1;
      end else if (in_flight) begin
        if (ack === req) in_flight = 1'b0;
        else chk("hold_data_out", data_out, held_dat);
      end
    end
  end

  initial begin
    int d0;
    rstn       = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    auto_ack   = 1'b0;
    rand_ack   = 1'b0;
    manual_ack = 1'b0;

    // Reset values
    repeat (3) @(negedge clkSrc);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data_out", data_out, 32'd0);
    rstn     = 1'b1;
    auto_ack = 1'b1;
    @(posedge clkSrc);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single word latency: data_out at edge 1, req at edge 2
    push_word(32'hDEADBEEF);
    @(negedge clkSrc);
    chk("e0_data_out", data_out, 32'd0);
    chk("e0_req", 32'(req), 32'd0);
    chk("e0_busy", 32'(busy), 32'd1);
    @(negedge clkSrc);
    chk("e1_data_out", data_out, 32'hDEADBEEF);
    chk("e1_req", 32'(req), 32'd0);
    @(negedge clkSrc);
    chk("e2_req", 32'(req), 32'd1);
    wait_idle(50);
    chk("single_q_empty", 32'(exp_q.size()), 32'd0);

    // Stray ack toggle while idle must be ignored
    manual_ack = ack;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    repeat (6) @(negedge clkSrc);
    chk("stray_req", 32'(req), 32'd1);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_data_out", data_out, 32'hDEADBEEF);
`ifdef BUS_HANDSHAKE_TX_STATS_EN
    chk("stray_sent_count", 32'(sent_count), 32'd1);
`endif
    manual_ack = 1'b1;
    repeat (4) @(negedge clkSrc);

    // Fill with ack held: one word stuck in flight, then 4 accepted and the 5th dropped
    push_word(32'h100);
    repeat (4) @(negedge clkSrc);
    chk("fill_req_toggled", 32'(req), 32'd0);
    push_word(32'h101);
    chk("fill_rdy1", 32'(in_ready), 32'd1);
    push_word(32'h102);
    chk("fill_rdy2", 32'(in_ready), 32'd1);
    push_word(32'h103);
    chk("fill_rdy3", 32'(in_ready), 32'd1);
    push_word(32'h104);
    chk("fill_rdy4", 32'(in_ready), 32'd0);
    push_word(32'h105);
    chk("fill_rdy5", 32'(in_ready), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    chk("fill_data_held", data_out, 32'h100);
`ifdef BUS_HANDSHAKE_TX_STATS_EN
    chk("fill_drop_count", 32'(drop_count), 32'd1);
`endif
    auto_ack = 1'b1;
    wait_idle(200);
    chk("fill_q_empty", 32'(exp_q.size()), 32'd0);
    chk("fill_in_ready", 32'(in_ready), 32'd1);

    // Order and pointer wrap with random ack delays
    rand_ack = 1'b1;
    d0 = delivered;
    for (int i = 1; i <= 10; i++) push_wait(32'(i));
    wait_idle(400);
    chk("order_delivered", 32'(delivered - d0), 32'd10);
    chk("order_q_empty", 32'(exp_q.size()), 32'd0);
    chk("order_last", data_out, 32'd10);
`ifdef BUS_HANDSHAKE_TX_STATS_EN
    chk("order_sent_count", 32'(sent_count), 32'd16);
`endif

    // Reset in WAIT_ACK with two words queued
    rand_ack   = 1'b0;
    manual_ack = ack;
    auto_ack   = 1'b0;
    push_word(32'h201);
    push_word(32'h202);
    push_word(32'h203);
    repeat (2) @(negedge clkSrc);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_data", data_out, 32'h201);
    #2;
    rstn       = 1'b0;
    manual_ack = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_data_out", data_out, 32'd0);
`ifdef BUS_HANDSHAKE_TX_STATS_EN
    chk("arst_sent_count", 32'(sent_count), 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clkSrc);
    chk("arst_ack", 32'(ack), 32'd0);
    rstn     = 1'b1;
    auto_ack = 1'b1;
    @(posedge clkSrc);
    #1;
    chk("post_arst_busy", 32'(busy), 32'd0);
    chk("post_arst_req", 32'(req), 32'd0);

    // Queued words were abandoned; a fresh word still flows
    d0 = delivered;
    push_word(32'h300);
    wait_idle(50);
    chk("post_arst_delivered", 32'(delivered - d0), 32'd1);
    chk("post_arst_data", data_out, 32'h300);
    chk("post_arst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
